// File: rtl/ip_instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ip_fetch_pkg
// Description : Shared types and constants for the instruction fetch front-end.
// Revision    : 1.0  initial release
// ============================================================================
package ip_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Opcode occupies the top OPC_W bits of every instruction word
    localparam int         OPC_W   = 8;
    localparam logic [7:0] HALT_OP = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/ip_instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ip_instr_fetch_if
// Description : Host-load, control and instruction hand-off bundle.
// Revision    : 1.0  initial release
// ============================================================================
interface ip_instr_fetch_if #(
    parameter int IW    = 256,
    parameter int AW    = 14,
    parameter int NBANK = 2
);
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

    logic          purge;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [BW-1:0] exec_bank;
    logic [AW-1:0] waddr;
    logic [BW-1:0] wbank;
    logic          wceb;
    logic [IW-1:0] wdata;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_addr;
    logic          instr_valid;
    logic          instr_ready;
    logic          busy;
    logic          halt_seen;
    logic          wr_conflict;

    modport master (
        output purge, start, start_addr, exec_bank,
        output waddr, wbank, wceb, wdata, instr_ready,
        input  instr, instr_addr, instr_valid, busy, halt_seen, wr_conflict
    );

    modport slave (
        input  purge, start, start_addr, exec_bank,
        input  waddr, wbank, wceb, wdata, instr_ready,
        output instr, instr_addr, instr_valid, busy, halt_seen, wr_conflict
    );

endinterface
`default_nettype wire

// File: rtl/ip_instr_mem.sv
`default_nettype none
// ============================================================================
// Module      : ip_instr_mem
// Description : NBANK x 2**AW x IW banked memory, 1-cycle synchronous read,
//               independent write port; read-during-write returns old data.
// Revision    : 1.0  initial release
// ============================================================================
module ip_instr_mem #(
    parameter int IW    = 256,
    parameter int AW    = 14,
    parameter int NBANK = 2,
    parameter int BW    = 1
) (
    input  wire logic          clk,
    input  wire logic          i_re,
    input  wire logic [BW-1:0] i_rbank,
    input  wire logic [AW-1:0] i_raddr,
    output logic      [IW-1:0] o_rdata,
    input  wire logic          i_we,
    input  wire logic [BW-1:0] i_wbank,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [IW-1:0] i_wdata
);

    logic [IW-1:0] r_mem [NBANK][2**AW];
    logic [IW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we && (int'(i_wbank) < NBANK)) begin
            r_mem[i_wbank][i_waddr] <= i_wdata;
        end
        if (i_re && (int'(i_rbank) < NBANK)) begin
            r_rdata <= r_mem[i_rbank][i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ip_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ip_instr_fetch
// Description : Banked instruction memory + fetch FSM with prefetch FIFO and
//               valid/ready hand-off. IFETCH_PERF_CNT_EN adds o_instr_count.
// Revision    : 1.0  initial release
// ============================================================================
module ip_instr_fetch
    import ip_fetch_pkg::*;
#(
    parameter int IW     = 256,
    parameter int AW     = 14,
    parameter int NBANK  = 2,
    parameter int FDEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ip_instr_fetch_if.slave   if_fetch
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       o_instr_count
`endif
);

    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_DRAIN = DRAIN;

    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [BW-1:0] r_bank;
    logic          r_inflight;
    logic [AW-1:0] r_rd_addr;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_fifo_data [FDEPTH];
    logic [AW-1:0] r_fifo_addr [FDEPTH];

    logic          w_start;
    logic          w_fetch_issue;
    logic          w_issue;
    logic [AW-1:0] w_raddr;
    logic [BW-1:0] w_rbank;
    logic [IW-1:0] w_rdata;
    logic          w_push;
    logic          w_halt_push;
    logic          w_valid;
    logic          w_pop;
    logic [IW-1:0] w_head;
    logic          w_halt_pop;

    // The START cycle itself issues the first read so the first word is
    // presented two cycles later.
    assign w_start       = (r_state == S_IDLE) && if_fetch.start && !if_fetch.purge;
    assign w_push        = r_inflight && !if_fetch.purge;
    assign w_halt_push   = w_push && (w_rdata[IW-1 -: OPC_W] == HALT_OP);
    assign w_fetch_issue = (r_state == S_FETCH) && !if_fetch.purge && !w_halt_push &&
                           ((r_count + CW'(r_inflight)) < CW'(FDEPTH));
    assign w_issue       = w_start || w_fetch_issue;
    assign w_raddr       = w_start ? if_fetch.start_addr : r_pc;
    assign w_rbank       = w_start ? if_fetch.exec_bank  : r_bank;

    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && if_fetch.instr_ready && !if_fetch.purge;
    assign w_head     = r_fifo_data[r_rptr];
    assign w_halt_pop = (r_state == S_DRAIN) && w_pop && (w_head[IW-1 -: OPC_W] == HALT_OP);

    ip_instr_mem #(
        .IW    (IW),
        .AW    (AW),
        .NBANK (NBANK),
        .BW    (BW)
    ) u_mem (
        .clk     (clk),
        .i_re    (w_issue),
        .i_rbank (w_rbank),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata),
        .i_we    (!if_fetch.wceb),
        .i_wbank (if_fetch.wbank),
        .i_waddr (if_fetch.waddr),
        .i_wdata (if_fetch.wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_bank     <= '0;
            r_inflight <= 1'b0;
            r_rd_addr  <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (if_fetch.purge) begin
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_addr <= w_raddr;
                r_pc      <= w_raddr + AW'(1);
            end
            if (w_start) begin
                r_bank <= if_fetch.exec_bank;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            case (r_state)
                S_IDLE:  if (w_start)     r_state <= S_FETCH;
                S_FETCH: if (w_halt_push) r_state <= S_DRAIN;
                S_DRAIN: if (w_halt_pop)  r_state <= S_IDLE;
                default:                  r_state <= S_IDLE;
            endcase
        end
    end

    // Entry storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= w_rdata;
            r_fifo_addr[r_wptr] <= r_rd_addr;
        end
    end

    assign if_fetch.instr       = w_valid ? w_head : '0;
    assign if_fetch.instr_addr  = w_valid ? r_fifo_addr[r_rptr] : '0;
    assign if_fetch.instr_valid = w_valid;
    assign if_fetch.busy        = (r_state != S_IDLE);
    assign if_fetch.halt_seen   = w_halt_pop;
    assign if_fetch.wr_conflict = (r_state != S_IDLE) && !if_fetch.wceb &&
                                  (if_fetch.wbank == r_bank);

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (w_start) begin
            r_instr_count <= '0;
        end else if (w_pop && (r_instr_count != '1)) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign o_instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ip_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_instr_fetch
// Description : Directed self-checking bench for ip_instr_fetch.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ip_instr_fetch;
    import ip_fetch_pkg::*;

    localparam int IW     = 256;
    localparam int AW     = 14;
    localparam int NBANK  = 2;
    localparam int FDEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ip_instr_fetch_if #(.IW(IW), .AW(AW), .NBANK(NBANK)) bus ();

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] instr_count;
`endif

    ip_instr_fetch #(
        .IW(IW), .AW(AW), .NBANK(NBANK), .FDEPTH(FDEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_fetch (bus)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .o_instr_count (instr_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] got_addr  [$];
    logic [IW-1:0] got_instr [$];
    int            halt_at;
    int            halt_cnt;
    int            first_valid;
    logic          busy_after;

    function automatic logic [IW-1:0] word(input logic [7:0] op, input logic [AW-1:0] a);
        return {op, 8'hA5, {(IW-16-AW){1'b0}}, a};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic hw_write(input logic bank, input logic [AW-1:0] a, input logic [IW-1:0] d);
        bus.wbank = bank;
        bus.waddr = a;
        bus.wdata = d;
        bus.wceb  = 1'b0;
        cyc();
        bus.wceb  = 1'b1;
    endtask

    // Runs one program with READY held high and records every hand-off.
    task automatic run_prog(input logic [AW-1:0] a, input logic bank, input int budget,
                            output bit timeout);
        got_addr.delete();
        got_instr.delete();
        halt_at     = -1;
        halt_cnt    = 0;
        first_valid = -1;
        timeout     = 1'b1;
        bus.start_addr  = a;
        bus.exec_bank   = bank;
        bus.instr_ready = 1'b1;
        bus.start       = 1'b1;
        for (int c = 0; c < budget; c++) begin
            smp();
            if (bus.instr_valid && first_valid < 0) first_valid = c;
            if (bus.halt_seen) begin
                halt_cnt++;
                halt_at = got_addr.size();
            end
            if (bus.instr_valid && bus.instr_ready) begin
                got_addr.push_back(bus.instr_addr);
                got_instr.push_back(bus.instr);
            end
            cyc();
            bus.start = 1'b0;
            if (halt_at >= 0) begin
                timeout = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        smp();
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        smp();
        smp();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.halt_seen !== 1'b0 ||
            bus.wr_conflict !== 1'b0 || bus.instr !== '0 || bus.instr_addr !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b busy=%0b halt=%0b conf=%0b addr=%0h want all 0",
                     bus.instr_valid, bus.busy, bus.halt_seen, bus.wr_conflict, bus.instr_addr);
        end
`ifdef IFETCH_PERF_CNT_EN
        checks++;
        if (instr_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d want 0", instr_count);
        end
`endif
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic [7:0] ops [5];
        bit to;
        ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        for (int i = 0; i < 5; i++) hw_write(1'b0, AW'(i), word(ops[i], AW'(i)));
        run_prog('0, 1'b0, 20, to);
        checks++;
        if (to) begin failures++; $display("FAIL basic_timeout: no HALT_SEEN within 20 cycles"); end
        checks++;
        if (first_valid != 2) begin
            failures++;
            $display("FAIL basic_latency: first valid at cycle %0d want 2", first_valid);
        end
        checks++;
        if (got_addr.size() != 5) begin
            failures++;
            $display("FAIL basic_count: got %0d words want 5", got_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < 5; i++) begin
            checks++;
            if (got_addr[i] !== AW'(i) || got_instr[i] !== word(ops[i], AW'(i))) begin
                failures++;
                $display("FAIL basic_word%0d: addr %0h want %0h", i, got_addr[i], i);
            end
        end
        checks++;
        if (halt_at != 4 || halt_cnt != 1) begin
            failures++;
            $display("FAIL basic_halt: at %0d cnt %0d want 4 cnt 1", halt_at, halt_cnt);
        end
        checks++;
        if (busy_after !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_after: got %0b want 0", busy_after);
        end
`ifdef IFETCH_PERF_CNT_EN
        checks++;
        if (instr_count !== 32'd5) begin
            failures++;
            $display("FAIL basic_perf_count: got %0d want 5", instr_count);
        end
`endif
    endtask

    task automatic test_stall();
        logic          pat [4];
        logic [7:0]    ops [5];
        int            k, maxocc, unstable, bad;
        bit            done;
        logic          pv, pr;
        logic [IW-1:0] pi;
        logic [AW-1:0] pa;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        k = 0; maxocc = 0; unstable = 0; bad = 0; done = 1'b0;
        pv = 1'b0; pr = 1'b1; pi = '0; pa = '0;
        bus.start_addr = '0;
        bus.exec_bank  = 1'b0;
        bus.start      = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            bus.instr_ready = pat[c % 4];
            smp();
            if (int'(dut.r_count) > maxocc) maxocc = int'(dut.r_count);
            if (pv && !pr && (!bus.instr_valid || bus.instr !== pi || bus.instr_addr !== pa))
                unstable++;
            if (bus.instr_valid && bus.instr_ready) begin
                if (k < 5) begin
                    if (bus.instr_addr !== AW'(k) || bus.instr !== word(ops[k], AW'(k))) bad++;
                end else begin
                    bad++;
                end
                if (bus.halt_seen) done = 1'b1;
                k++;
            end
            pv = bus.instr_valid; pr = bus.instr_ready; pi = bus.instr; pa = bus.instr_addr;
            cyc();
            bus.start = 1'b0;
        end
        bus.instr_ready = 1'b1;
        checks++;
        if (!done) begin failures++; $display("FAIL stall_timeout: halt not handed off in 60 cycles"); end
        checks++;
        if (k != 5 || bad != 0) begin
            failures++;
            $display("FAIL stall_sequence: got %0d words (%0d wrong) want 5 (0 wrong)", k, bad);
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL stall_stability: %0d unstable stall cycles want 0", unstable);
        end
        checks++;
        if (maxocc > FDEPTH) begin
            failures++;
            $display("FAIL stall_occupancy: max %0d want <= %0d", maxocc, FDEPTH);
        end
        smp();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_busy_after: got %0b want 0", bus.busy);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea  [4];
        logic [7:0]    ops [4];
        bit to;
        ea  = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        ops = '{8'h10, 8'h11, 8'h12, 8'hFF};
        for (int i = 0; i < 4; i++) hw_write(1'b0, ea[i], word(ops[i], ea[i]));
        run_prog(14'h3FFE, 1'b0, 20, to);
        checks++;
        if (to || got_addr.size() != 4) begin
            failures++;
            $display("FAIL wrap_count: got %0d words timeout=%0b want 4", got_addr.size(), to);
        end
        for (int i = 0; i < got_addr.size() && i < 4; i++) begin
            checks++;
            if (got_addr[i] !== ea[i] || got_instr[i] !== word(ops[i], ea[i])) begin
                failures++;
                $display("FAIL wrap_word%0d: addr %0h want %0h", i, got_addr[i], ea[i]);
            end
        end
        checks++;
        if (halt_at != 3) begin
            failures++;
            $display("FAIL wrap_halt: at index %0d want 3", halt_at);
        end
    endtask

    task automatic test_purge();
        bit to;
        int hs;
        for (int i = 0; i < 10; i++)
            hw_write(1'b1, AW'(20 + i), word((i == 9) ? 8'hFF : 8'(8'h20 + i), AW'(20 + i)));
        hs = 0;
        bus.start_addr  = AW'(20);
        bus.exec_bank   = 1'b1;
        bus.instr_ready = 1'b1;
        bus.start       = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        bus.purge = 1'b1;
        smp();
        if (bus.halt_seen) hs++;
        cyc();
        bus.purge = 1'b0;
        smp();
        if (bus.halt_seen) hs++;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL purge_flush: valid=%0b busy=%0b want 0 0", bus.instr_valid, bus.busy);
        end
        cyc();
        smp();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL purge_inflight: valid=%0b want 0", bus.instr_valid);
        end
        bus.purge = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.purge = 1'b0;
        bus.start = 1'b0;
        smp();
        checks++;
        if (bus.busy !== 1'b0 || hs != 0) begin
            failures++;
            $display("FAIL purge_start_ignored: busy=%0b halts=%0d want 0 0", bus.busy, hs);
        end
        run_prog(AW'(20), 1'b1, 30, to);
        checks++;
        if (to || got_addr.size() != 10 || halt_at != 9) begin
            failures++;
            $display("FAIL purge_refetch_count: got %0d words halt %0d want 10 halt 9",
                     got_addr.size(), halt_at);
        end
        for (int i = 0; i < got_addr.size() && i < 10; i += 3) begin
            checks++;
            if (got_addr[i] !== AW'(20 + i)) begin
                failures++;
                $display("FAIL purge_refetch_word%0d: addr %0h want %0h", i, got_addr[i], 20 + i);
            end
        end
    endtask

    task automatic test_conflict();
        bit to;
        bus.wbank = 1'b0; bus.waddr = AW'(7); bus.wdata = word(8'h70, AW'(7)); bus.wceb = 1'b0;
        smp();
        checks++;
        if (bus.wr_conflict !== 1'b0) begin
            failures++;
            $display("FAIL conflict_idle: got %0b want 0", bus.wr_conflict);
        end
        cyc();
        bus.wceb = 1'b1;
        bus.start_addr  = '0;
        bus.exec_bank   = 1'b0;
        bus.instr_ready = 1'b0;
        bus.start       = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.wbank = 1'b0; bus.waddr = AW'(7); bus.wdata = word(8'h77, AW'(7)); bus.wceb = 1'b0;
        smp();
        checks++;
        if (bus.wr_conflict !== 1'b1) begin
            failures++;
            $display("FAIL conflict_same_bank: got %0b want 1", bus.wr_conflict);
        end
        cyc();
        bus.wceb = 1'b1;
        smp();
        checks++;
        if (bus.wr_conflict !== 1'b0) begin
            failures++;
            $display("FAIL conflict_pulse_width: got %0b want 0", bus.wr_conflict);
        end
        bus.wbank = 1'b1; bus.waddr = AW'(7); bus.wdata = word(8'h55, AW'(7)); bus.wceb = 1'b0;
        smp();
        checks++;
        if (bus.wr_conflict !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL conflict_other_bank: conf=%0b busy=%0b want 0 1", bus.wr_conflict, bus.busy);
        end
        cyc();
        bus.wceb = 1'b1;
        hw_write(1'b1, AW'(8), word(8'hFF, AW'(8)));
        bus.purge = 1'b1;
        cyc();
        bus.purge = 1'b0;
        run_prog(AW'(7), 1'b1, 20, to);
        checks++;
        if (to || got_addr.size() != 2 || halt_at != 1) begin
            failures++;
            $display("FAIL conflict_readback_count: got %0d words halt %0d want 2 halt 1",
                     got_addr.size(), halt_at);
        end
        checks++;
        if (got_addr.size() < 1 || got_instr[0] !== word(8'h55, AW'(7))) begin
            failures++;
            $display("FAIL conflict_readback_data: opcode %0h want 55",
                     (got_instr.size() > 0) ? got_instr[0][IW-1 -: 8] : 8'h00);
        end
    endtask

    task automatic test_reset_midrun();
        bus.start_addr  = AW'(20);
        bus.exec_bank   = 1'b1;
        bus.instr_ready = 1'b1;
        bus.start       = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        cyc();
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        smp();
        checks++;
        if (bus.instr_valid !== 1'b1 || int'(dut.r_count) != FDEPTH ||
            bus.instr_addr !== AW'(22)) begin
            failures++;
            $display("FAIL midrun_full: valid=%0b occ=%0d head=%0h want 1 %0d 16",
                     bus.instr_valid, dut.r_count, bus.instr_addr, FDEPTH);
        end
`ifdef IFETCH_PERF_CNT_EN
        checks++;
        if (instr_count !== 32'd2) begin
            failures++;
            $display("FAIL midrun_count_pre: got %0d want 2", instr_count);
        end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.halt_seen !== 1'b0 ||
            bus.wr_conflict !== 1'b0 || bus.instr !== '0 || bus.instr_addr !== '0) begin
            failures++;
            $display("FAIL midrun_async_reset: valid=%0b busy=%0b addr=%0h want all 0",
                     bus.instr_valid, bus.busy, bus.instr_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        cyc();
        smp();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_after_release: valid=%0b busy=%0b want 0 0",
                     bus.instr_valid, bus.busy);
        end
`ifdef IFETCH_PERF_CNT_EN
        checks++;
        if (instr_count !== 32'd0) begin
            failures++;
            $display("FAIL midrun_count_post: got %0d want 0", instr_count);
        end
`endif
    endtask

    initial begin
        bus.purge       = 1'b0;
        bus.start       = 1'b0;
        bus.start_addr  = '0;
        bus.exec_bank   = 1'b0;
        bus.waddr       = '0;
        bus.wbank       = 1'b0;
        bus.wceb        = 1'b1;
        bus.wdata       = '0;
        bus.instr_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_purge();
        test_conflict();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ip_instr_fetch.md
Name: ip_instr_fetch

Overview:
- Parametrised successor of the instruction front-end: a banked instruction memory plus a fetch engine with a prefetch FIFO and a valid/ready output.
- Host loads programs through a write port into one bank while the sequencer executes from the other bank (ping-pong).
- Sits between the host load path and the layer sequencer, replacing the old fixed single-word RADDRI/RCEBI/QI coupling.

Parameters:
- IW, 256, instruction width in bits.
- AW, 14, word address width; each bank holds 2**AW words.
- NBANK, 2, number of banks; bank select width is BW = clog2(NBANK), minimum 1.
- FDEPTH, 4, prefetch FIFO depth in entries; power of two, at least 2.

Ports:
- CLK  in  1  clock.
- RSTL  in  1  asynchronous active-low reset.
- PURGE  in  1  synchronous flush of the fetch engine.
- START  in  1  one-cycle start pulse; honoured only in IDLE.
- START_ADDR  in  AW  first fetch address.
- EXEC_BANK  in  BW  bank to execute from; sampled on START.
- WADDRI  in  AW  host write address.
- BANKI  in  BW  host write bank.
- WCEBI  in  1  host write enable, active low.
- DI  in  IW  host write data.
- INSTR  out  IW  instruction at FIFO head.
- INSTR_ADDR  out  AW  address of the instruction at FIFO head.
- INSTR_VALID  out  1  FIFO head valid.
- INSTR_READY  in  1  sequencer accepts the head.
- BUSY  out  1  high whenever state is not IDLE.
- HALT_SEEN  out  1  one-cycle pulse when the halt instruction is handed off.
- WR_CONFLICT  out  1  one-cycle pulse when the host writes the executing bank while BUSY.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, PC 0, no read in flight.
- Memory:
  - Synchronous read with 1-cycle latency.
  - A write occurs when WCEBI==0.
  - A read and a write to the same bank/address in the same cycle returns the old data.
  - Out-of-range BANKI (>= NBANK) is ignored.
- States: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on START: PC <= START_ADDR, bank <= EXEC_BANK.
  - In FETCH, a read is issued when (FIFO count + in-flight) < FDEPTH. Each issue increments PC, wrapping from 2**AW-1 to 0.
  - Read data is pushed into the FIFO the cycle after issue, tagged with its address.
  - Halt detection: a pushed word with INSTR[IW-1:IW-8] == HALT_OP (8'hFF) stops further issue.
    - FETCH -> DRAIN on that push.
    - Any read already in flight behind the halt word is discarded.
  - DRAIN -> IDLE once the halt word is accepted (INSTR_VALID & INSTR_READY). HALT_SEEN pulses in that same cycle.
- Handshake:
  - Pop on INSTR_VALID & INSTR_READY.
  - INSTR, INSTR_ADDR and INSTR_VALID are stable while VALID is high and READY is low.
  - A push and a pop in the same cycle are both allowed when the FIFO is full, so a full FIFO sustains 1 word per cycle.
- PURGE: highest priority after reset. It empties the FIFO, drops any in-flight read, and forces IDLE next cycle. A START in the same cycle is ignored. HALT_SEEN is not asserted.
- START while not IDLE is ignored.
- WR_CONFLICT asserts when BUSY & !WCEBI & BANKI == the latched bank. The write still takes effect.
- Throughput after START: the first INSTR_VALID appears 2 cycles after the START cycle; thereafter 1 word per cycle while READY is held high.

Optional Feature:
- IFETCH_PERF_CNT_EN:
  - Defined: adds output INSTR_COUNT (32 bits). It counts accepted handshakes, clears on START and reset, and saturates at 2**32-1.
  - Undefined: the port and its counter are absent.

Decomposition:
- Package ip_fetch_pkg holds:
  - the fetch_state_t enum (IDLE, FETCH, DRAIN);
  - HALT_OP = 8'hFF;
  - the opcode field position constant (top 8 bits of the instruction).
- One sub-module, ip_instr_mem: the NBANK x 2**AW x IW banked synchronous memory with separate read and write ports.
- The FIFO and the FSM live inline.

Test Plan:
1. Load bank0 addr 0..4 with opcodes 01,02,03,04,FF; START addr 0, READY held 1 -> INSTR_ADDR 0,1,2,3,4 on consecutive cycles; first VALID 2 cycles after START; HALT_SEEN pulses with addr 4; BUSY drops the next cycle.
2. Same program, READY toggling 1,0,0,1 -> no word lost or duplicated; INSTR stable during stalls; FIFO never exceeds 4 entries.
3. Load halt at addr 1 only; START addr 2**AW-2 -> fetched addresses 3FFE, 3FFF, 0000, 0001, showing wrap; halt recognised at 0001.
4. PURGE asserted 3 cycles into a 10-word run -> INSTR_VALID=0 the next cycle; BUSY=0; no HALT_SEEN; a fresh START re-fetches from START_ADDR correctly.
5. While executing bank0, host writes bank0 addr 7 -> WR_CONFLICT pulses once; a write to bank1 raises no pulse; a later run from bank1 returns the written data.
6. Assert RSTL low mid-run with the FIFO full -> all outputs 0 asynchronously; after release, state IDLE and FIFO empty; with IFETCH_PERF_CNT_EN defined, INSTR_COUNT is 0.
